// File: rtl/matrix_frame_sched.sv
// matrix_frame_sched
//   Two-source arbiter and row scanner for a 5x7 dot-matrix display.
//   Rows are scanned one per clk_div cycle; arbitration and the frame
//   snapshot (shadow) happen only on the edge that ends row 6, so every
//   scanned frame is tear-free and belongs to a single source.
//
// Ports
//   clk_div    in   row-scan clock, rising edge
//   reset      in   synchronous, active-high
//   req_a      in   source A display request (level)
//   frame_a    in   35-bit frame, bit r*5+c = row r, column c
//   req_b      in   source B display request (level)
//   frame_b    in   35-bit frame, same mapping as frame_a
//   col        out  column drive of the active row, 1 = lit
//   row_n      out  active-low row enables, one-hot low
//   grant_a    out  source A owns the display
//   grant_b    out  source B owns the display
//   frame_done out  high while row 6 is scanned
module matrix_frame_sched #(
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk_div,
    input  logic        reset,
    input  logic        req_a,
    input  logic [34:0] frame_a,
    input  logic        req_b,
    input  logic [34:0] frame_b,
    output logic [4:0]  col,
    output logic [6:0]  row_n,
    output logic        grant_a,
    output logic        grant_b,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_FRAMES);

    state_t      state, state_d;
    logic [2:0]  row;
    logic [3:0]  hold, hold_d, hold_inc;
    logic [34:0] shadow, shadow_d;
    logic        boundary;
    logic        hold_done;

    assign boundary = (row == 3'd6);

    // The frame ending at this boundary already counts toward the hold, so
    // a source keeps the display for exactly HOLD_FRAMES frames under
    // contention.
    assign hold_inc  = (hold == HOLD_MAX) ? hold : hold + 4'd1;
    assign hold_done = (hold_inc == HOLD_MAX);

    always_ff @(posedge clk_div) begin
        if (reset) begin
            row    <= 3'd0;
            state  <= IDLE;
            hold   <= '0;
            shadow <= '0;
        end else begin
            row    <= boundary ? 3'd0 : row + 3'd1;
            state  <= state_d;
            hold   <= hold_d;
            shadow <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state;
        hold_d   = hold;
        shadow_d = shadow;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (req_a)      state_d = SHOW_A;
                    else if (req_b) state_d = SHOW_B;
                    else            state_d = IDLE;
                end
                SHOW_A: begin
                    if (!req_a)                  state_d = req_b ? SHOW_B : IDLE;
                    else if (req_b && hold_done) state_d = SHOW_B;
                    else                         state_d = SHOW_A;
                end
                SHOW_B: begin
                    if (!req_b)                  state_d = req_a ? SHOW_A : IDLE;
                    else if (req_a && hold_done) state_d = SHOW_A;
                    else                         state_d = SHOW_B;
                end
                default: state_d = IDLE;
            endcase

            if (state_d != state || state == IDLE) hold_d = '0;
            else                                   hold_d = hold_inc;

            case (state_d)
                SHOW_A:  shadow_d = frame_a;
                SHOW_B:  shadow_d = frame_b;
                default: shadow_d = '0;
            endcase
        end
    end

    always_comb begin
        col   = '0;
        row_n = '1;
        for (int unsigned r = 0; r < 7; r++) begin
            if (row == r[2:0]) begin
                col      = shadow[r*5 +: 5];
                row_n[r] = 1'b0;
            end
        end
    end

    assign grant_a    = (state == SHOW_A);
    assign grant_b    = (state == SHOW_B);
    assign frame_done = boundary;

endmodule

// File: doc/matrix_frame_sched.md
MATRIX_FRAME_SCHED -- requirements
Module: matrix_frame_sched

Interface
REQ-001 Parameter: HOLD_FRAMES, default 4, minimum number of complete frames a granted source keeps the display; legal range 1..15.
REQ-002 Port: clk_div  input  1  row-scan clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_a  input  1  source A requests the display; level-sensitive.
REQ-005 Port: frame_a  input  35  source A frame; bit r*5+c = pixel at row r (0..6), column c (0=a..4=e); 1 = lit.
REQ-006 Port: req_b  input  1  source B requests the display; level-sensitive.
REQ-007 Port: frame_b  input  35  source B frame; same bit mapping as frame_a.
REQ-008 Port: col  output  5  column drive for the active row; col[0]=ca .. col[4]=ce; 1 = lit.
REQ-009 Port: row_n  output  7  row enables, active-low, exactly one bit low at all times; row_n[r] = line r.
REQ-010 Port: grant_a  output  1  high while source A owns the display.
REQ-011 Port: grant_b  output  1  high while source B owns the display.
REQ-012 Port: frame_done  output  1  high during the cycle in which row 6 is scanned.

Function
REQ-013 Row counter: 3 bits, increments by 1 each cycle, wraps 6->0; value 7 is never reached.
REQ-014 row_n SHALL be low only at bit [row counter], decoded from the registered counter.
REQ-015 col SHALL equal shadow[row*5+4 : row*5] of a 35-bit shadow frame register; col is combinational from registered state, so it has no added latency.
REQ-016 Frame boundary: the cycle where row counter = 6. All arbitration and shadow loads happen only on the edge ending a boundary cycle.
REQ-017 FSM states: IDLE, SHOW_A, SHOW_B. grant_a = (state==SHOW_A); grant_b = (state==SHOW_B).
REQ-018 IDLE at boundary: req_a -> SHOW_A; else req_b -> SHOW_B; else stay IDLE.
REQ-019 IDLE at boundary, req_a and req_b both high: A wins.
REQ-020 SHOW_x at boundary, owner request low: switch to the other source if it requests, else go to IDLE.
REQ-021 SHOW_x at boundary, owner request high, other source requesting, hold count reached HOLD_FRAMES: switch to the other source (round-robin).
REQ-022 SHOW_x at boundary, owner request high, hold count not reached or other source idle: stay in SHOW_x.
REQ-023 Hold counter: 4 bits; cleared to 0 on every state change; otherwise incremented at each boundary while in SHOW_A/SHOW_B; saturates at HOLD_FRAMES.
REQ-024 Shadow load at each boundary edge, from the next state: frame_a if SHOW_A, frame_b if SHOW_B, all zeros if IDLE.
REQ-025 A new grant first appears on row 0 in the cycle after the boundary; grant outputs change on that same edge.
REQ-026 frame_a/frame_b changes outside the boundary cycle SHALL NOT affect col until the next boundary; each scanned frame is tear-free.
REQ-027 Request toggles between boundaries SHALL be ignored; only the level at the boundary cycle counts.
REQ-028 In IDLE, col SHALL be 00000 while row scanning continues.

Reset
REQ-029 While reset is high at a clk_div edge, the next state SHALL be: row counter 0, state IDLE, hold 0, shadow all zeros.
REQ-030 Output values under reset: row_n=1111110, col=00000, grant_a=0, grant_b=0, frame_done=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; scanning resumes at row 0 on the first cycle after reset deasserts.
REQ-032 Arbitration after reset: the first grant SHALL occur at the first boundary (7th cycle after reset release).

Verification
REQ-033 Stimulus: reset, then no requests for 14 cycles. Required response: row_n walks 1111110..0111111 twice, col=00000 throughout, frame_done high on cycles 7 and 14.
REQ-034 Stimulus: req_a=1, frame_a=all ones, asserted mid-frame. Required response: grant_a rises after the next boundary, and col=11111 on rows 0..6.
REQ-035 Stimulus: req_a and req_b both held high, HOLD_FRAMES=2. Required response: A is granted first, the display alternates A,A,B,B,A..., and grant switches occur only after a frame_done cycle.
REQ-036 Stimulus: frame_a changed from 0 to all ones while row=3. Required response: rows 3..6 of that frame still show 0, and the next frame shows 11111.
REQ-037 Stimulus: owner A drops req_a while req_b=0. Required response: at the next boundary the state goes to IDLE, grant_a=0, and col=00000 from row 0.
REQ-038 Stimulus: reset pulse while row=4 in SHOW_B. Required response: grant_b=0, row_n=1111110 and col=00000 the next cycle.
